// File: rtl/line_full_scanner.sv
// -----------------------------------------------------------------------------
// line_full_scanner
//
// Walks the 20x10 game board through the shared board-memory read port, one
// cell per cycle in row-major order, and builds the line_full vector consumed
// by the line-clear engine. A row is full when none of its cells holds
// NULL_PIECE. When the walk completes, scan_done rises and line_full and
// line_count stay frozen until enable falls or reset asserts.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   enable     in   level; low behaves exactly like reset
//   cell_data  in   board read data for the address presented last cycle
//   pos_i      out  row address (0 = top row)
//   pos_j      out  column address
//   read       out  memory read strobe
//   line_full  out  bit r set means row r is full
//   line_count out  number of set bits in line_full
//   scan_done  out  line_full / line_count are valid and stable
// -----------------------------------------------------------------------------
module line_full_scanner #(
  parameter int         BOARD_HEIGHT = 20,
  parameter int         BOARD_WIDTH  = 10,
  parameter logic [2:0] NULL_PIECE   = 3'd0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [2:0]            cell_data,
  output logic [4:0]            pos_i,
  output logic [4:0]            pos_j,
  output logic                  read,
  output logic [0:BOARD_HEIGHT-1] line_full,
  output logic [4:0]            line_count,
  output logic                  scan_done
);

  localparam logic [4:0] LAST_I = 5'(BOARD_HEIGHT - 1);
  localparam logic [4:0] LAST_J = 5'(BOARD_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  // Address/strobe of the previous cycle: tags the cell_data arriving now.
  logic [4:0] r_tag_i;
  logic [4:0] r_tag_j;
  logic       r_tag_valid;

  // Every cell of the current row seen so far was non-null.
  logic       r_row_ok;

  logic       w_clear;
  logic       w_last_addr;
  logic       w_cell_ok;
  logic       w_row_full;

  assign w_clear     = reset || !enable;
  assign w_last_addr = (pos_i == LAST_I) && (pos_j == LAST_J);
  assign w_cell_ok   = (cell_data != NULL_PIECE);
  assign w_row_full  = r_row_ok && w_cell_ok;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment first guarantees every path drives
  // w_state_next, so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    w_state_next = SCAN;
      SCAN:    if (w_last_addr) w_state_next = DRAIN;
      DRAIN:   w_state_next = DONE;
      DONE:    w_state_next = DONE;
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Address generator and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_clear) begin
      pos_i     <= '0;
      pos_j     <= '0;
      read      <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          pos_i <= '0;
          pos_j <= '0;
          read  <= 1'b1;
        end
        SCAN: begin
          if (w_last_addr) begin
            // Hold the final address; the last datum is still in flight.
            read <= 1'b0;
          end else if (pos_j == LAST_J) begin
            pos_j <= '0;
            pos_i <= pos_i + 5'd1;
          end else begin
            pos_j <= pos_j + 5'd1;
          end
        end
        DRAIN: begin
          read      <= 1'b0;
          scan_done <= 1'b1;
        end
        DONE: begin
          read      <= 1'b0;
          scan_done <= 1'b1;
        end
        default: begin
          read      <= 1'b0;
          scan_done <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Data path: evaluate each returned cell against its one-cycle-old tag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_tag_i     <= '0;
      r_tag_j     <= '0;
      r_tag_valid <= 1'b0;
      r_row_ok    <= 1'b1;
      line_full   <= '0;
      line_count  <= '0;
    end else begin
      r_tag_i     <= pos_i;
      r_tag_j     <= pos_j;
      r_tag_valid <= read;

      if (r_tag_valid) begin
        if (r_tag_j == LAST_J) begin
          // Row complete: commit its verdict and start fresh for the next row.
          line_full[r_tag_i] <= w_row_full;
          line_count         <= line_count + {4'd0, w_row_full};
          r_row_ok           <= 1'b1;
        end else begin
          r_row_ok <= w_row_full;
        end
      end
    end
  end

endmodule
